// File: rtl/controlador_contador.sv
// Count sequencer: runs a prescaled counter from 0 up to a latched limit,
// with pause, abort, one-shot and auto-reload modes.
module controlador_contador #(
    parameter int unsigned ANCHO     = 4,
    parameter int unsigned PRESCALER = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inicio,
    input  logic             i_pausa,
    input  logic             i_parar,
    input  logic             i_continuo,
    input  logic [ANCHO-1:0] i_limite,
    output logic [ANCHO-1:0] o_cuenta,
    output logic             o_fin,
    output logic             o_ocupado,
    output logic [1:0]       o_estado
);

    localparam int unsigned PW = $clog2(PRESCALER) + 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALER - 1);

    typedef enum logic [1:0] {
        REPOSO    = 2'b00,
        CONTANDO  = 2'b01,
        PAUSADO   = 2'b10,
        TERMINADO = 2'b11
    } estado_t;

    estado_t          state_q, state_d;
    logic [ANCHO-1:0] cuenta_q, cuenta_d;
    logic [ANCHO-1:0] limite_q, limite_d;
    logic             continuo_q, continuo_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             fin_q, fin_d;
    logic             tick_c;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= REPOSO;
            cuenta_q   <= '0;
            limite_q   <= '0;
            continuo_q <= 1'b0;
            presc_q    <= '0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cuenta_q   <= cuenta_d;
            limite_q   <= limite_d;
            continuo_q <= continuo_d;
            presc_q    <= presc_d;
            fin_q      <= fin_d;
        end
    end

    assign tick_c = (state_q == CONTANDO) && (presc_q == PRESC_MAX) && !i_pausa;

    // Next-state and datapath update; abort outranks everything but reset
    always_comb begin
        state_d    = state_q;
        cuenta_d   = cuenta_q;
        limite_d   = limite_q;
        continuo_d = continuo_q;
        presc_d    = presc_q;
        fin_d      = 1'b0;

        if (i_parar && (state_q != REPOSO)) begin
            state_d  = REPOSO;
            cuenta_d = '0;
            presc_d  = '0;
        end else begin
            case (state_q)
                REPOSO, TERMINADO: begin
                    if (state_q == REPOSO) begin
                        cuenta_d = '0;
                    end
                    if (i_inicio) begin
                        limite_d   = i_limite;
                        continuo_d = i_continuo;
                        cuenta_d   = '0;
                        presc_d    = '0;
                        state_d    = CONTANDO;
                    end
                end
                CONTANDO: begin
                    if (i_pausa) begin
                        state_d = PAUSADO;
                    end else if (tick_c) begin
                        presc_d = '0;
                        if (cuenta_q != limite_q) begin
                            cuenta_d = cuenta_q + 1'b1;
                        end else if (continuo_q) begin
                            cuenta_d = '0;
                            fin_d    = 1'b1;
                        end else begin
                            fin_d   = 1'b1;
                            state_d = TERMINADO;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSADO: begin
                    if (!i_pausa) begin
                        state_d = CONTANDO;
                    end
                end
                default: state_d = REPOSO;
            endcase
        end
    end

    assign o_cuenta  = cuenta_q;
    assign o_fin     = fin_q;
    assign o_estado  = state_q;
    assign o_ocupado = (state_q == CONTANDO) || (state_q == PAUSADO);

endmodule

// File: tb/tb_controlador_contador.sv
// Directed bench for controlador_contador: one instance at PRESCALER=1, one at PRESCALER=3.
module tb_controlador_contador;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_inicio, a_pausa, a_parar, a_continuo;
    logic [3:0] a_limite, a_cuenta;
    logic       a_fin, a_ocupado;
    logic [1:0] a_estado;
    logic       b_inicio, b_pausa, b_parar, b_continuo;
    logic [3:0] b_limite, b_cuenta;
    logic       b_fin, b_ocupado;
    logic [1:0] b_estado;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controlador_contador #(.ANCHO(4), .PRESCALER(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_inicio(a_inicio), .i_pausa(a_pausa),
        .i_parar(a_parar), .i_continuo(a_continuo), .i_limite(a_limite),
        .o_cuenta(a_cuenta), .o_fin(a_fin), .o_ocupado(a_ocupado), .o_estado(a_estado)
    );

    controlador_contador #(.ANCHO(4), .PRESCALER(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_inicio(b_inicio), .i_pausa(b_pausa),
        .i_parar(b_parar), .i_continuo(b_continuo), .i_limite(b_limite),
        .o_cuenta(b_cuenta), .o_fin(b_fin), .o_ocupado(b_ocupado), .o_estado(b_estado)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int c, input int f, input int e, input int o);
        chk({tag, ".cuenta"},  32'(a_cuenta),  32'(c));
        chk({tag, ".fin"},     32'(a_fin),     32'(f));
        chk({tag, ".estado"},  32'(a_estado),  32'(e));
        chk({tag, ".ocupado"}, 32'(a_ocupado), 32'(o));
    endtask

    // One-shot limit 3: values after each edge from the start edge on
    int os_c[6] = '{0, 1, 2, 3, 3, 3};
    int os_f[6] = '{0, 0, 0, 0, 1, 0};
    int os_e[6] = '{1, 1, 1, 1, 3, 3};
    // Auto-reload limit 2
    int ar_c[7] = '{0, 1, 2, 0, 1, 2, 0};
    int ar_f[7] = '{0, 0, 0, 1, 0, 0, 1};
    // PRESCALER=3, limit 1, pause on edges 2..6; resume edge 7 does not advance the prescaler
    int pb_c[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    int pb_f[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int pb_e[14] = '{1, 1, 2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 3, 3};

    initial begin
        rst = 1'b1;
        {a_inicio, a_pausa, a_parar, a_continuo} = '0;
        {b_inicio, b_pausa, b_parar, b_continuo} = '0;
        a_limite = '0;
        b_limite = '0;

        // Reset
        step();
        step();
        chk_a("rst", 0, 0, 0, 0);
        chk("rst_b.estado", 32'(b_estado), 32'd0);
        rst = 1'b0;
        step();
        chk_a("idle", 0, 0, 0, 0);

        // One-shot, limit 3
        a_limite = 4'd3; a_continuo = 1'b0; a_inicio = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            a_inicio = 1'b0;
            chk_a($sformatf("oneshot%0d", i), os_c[i], os_f[i], os_e[i], (os_e[i] == 1) ? 1 : 0);
        end

        // Restart from TERMINADO in auto-reload mode, limit 2
        a_limite = 4'd2; a_continuo = 1'b1; a_inicio = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            a_inicio = 1'b0;
            chk_a($sformatf("reload%0d", i), ar_c[i], ar_f[i], 1, 1);
        end

        // Abort from CONTANDO
        a_parar = 1'b1;
        step();
        a_parar = 1'b0;
        chk_a("abort", 0, 0, 0, 0);

        // Abort coincident with the terminal tick suppresses fin
        a_limite = 4'd1; a_continuo = 1'b0; a_inicio = 1'b1;
        step();
        a_inicio = 1'b0;
        chk_a("abt_t0", 0, 0, 1, 1);
        step();
        chk_a("abt_t1", 1, 0, 1, 1);
        a_parar = 1'b1;
        step();
        a_parar = 1'b0;
        chk_a("abt_term", 0, 0, 0, 0);
        step();
        chk_a("abt_after", 0, 0, 0, 0);

        // Full range 0..15 one-shot; a start pulse mid-count must be ignored
        a_limite = 4'd15; a_continuo = 1'b0; a_inicio = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            a_inicio = (i == 5);
            a_limite = (i == 5) ? 4'd0 : 4'd15;
            chk_a($sformatf("full%0d", i), i, 0, 1, 1);
        end
        a_inicio = 1'b0;
        step();
        chk_a("full_fin", 15, 1, 3, 0);

        // From TERMINADO, limit 0
        a_limite = 4'd0; a_inicio = 1'b1;
        step();
        a_inicio = 1'b0;
        chk_a("lim0_a", 0, 0, 1, 1);
        step();
        chk_a("lim0_b", 0, 1, 3, 0);

        // Reset mid-count
        a_limite = 4'd3; a_inicio = 1'b1;
        step();
        a_inicio = 1'b0;
        step();
        chk_a("pre_rst", 1, 0, 1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_a("mid_rst", 0, 0, 0, 0);

        // Prescaled count with a pause; a start pulse while paused is ignored
        b_limite = 4'd1; b_continuo = 1'b0; b_inicio = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            b_inicio = (i == 3);
            b_limite = (i == 3) ? 4'd3 : 4'd1;
            b_pausa  = (i >= 1) && (i <= 5);
            chk($sformatf("presc%0d.cuenta", i), 32'(b_cuenta), 32'(pb_c[i]));
            chk($sformatf("presc%0d.fin", i),    32'(b_fin),    32'(pb_f[i]));
            chk($sformatf("presc%0d.estado", i), 32'(b_estado), 32'(pb_e[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
